// File: rtl/rrv_pkg.sv
// Shared types and constants for the rrv program loader.
package rrv_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_LOAD  = 3'd1,
    LDR_DONE  = 3'd2,
    LDR_ERROR = 3'd3
  } t_ldr_state;

  localparam int LDR_WORD_BYTES = 4;

  // One-hot byte-enable bit for a lane within a 32-bit word.
  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/rrv_byte_packer.sv
// Packs accepted stream bytes into little-endian 32-bit words and issues a
// registered RAM write when a word fills or the image ends.
module rrv_byte_packer
  import rrv_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [ADDR_W-1:0] byte_addr,
  input  logic [7:0]        data,
  input  logic              last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_be
);

  logic [31:0] word_buf;
  logic [3:0]  be_acc;
  logic [1:0]  lane;
  logic [31:0] merged_data;
  logic [3:0]  merged_be;
  logic        flush;

  assign lane  = byte_addr[1:0];
  assign flush = accept && (last || (lane == 2'(LDR_WORD_BYTES - 1)));

  // Word buffer with the incoming byte merged into its lane.
  always_comb begin
    merged_data = word_buf;
    merged_be   = be_acc;
    if (accept) begin
      merged_data[{lane, 3'b000} +: 8] = data;
      merged_be                        = be_acc | lane_mask(lane);
    end else begin
      merged_data = word_buf;
      merged_be   = be_acc;
    end
  end

  // Accumulate lanes; on flush, register the write and start an empty word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_buf <= 32'h0000_0000;
      be_acc   <= 4'b0000;
      wr_en    <= 1'b0;
      wr_addr  <= {ADDR_W{1'b0}};
      wr_data  <= 32'h0000_0000;
      wr_be    <= 4'b0000;
    end else if (clear) begin
      word_buf <= 32'h0000_0000;
      be_acc   <= 4'b0000;
      wr_en    <= 1'b0;
    end else if (flush) begin
      wr_en    <= 1'b1;
      wr_addr  <= {byte_addr[ADDR_W-1:2], 2'b00};
      wr_data  <= merged_data;
      wr_be    <= merged_be;
      word_buf <= 32'h0000_0000;
      be_acc   <= 4'b0000;
    end else begin
      wr_en    <= 1'b0;
      word_buf <= merged_data;
      be_acc   <= merged_be;
    end
  end

endmodule

// File: rtl/rrv_imem_loader.sv
// Program loader: streams a byte image into instruction RAM and keeps the
// rrv core in reset until the image has been completely written.
module rrv_imem_loader
  import rrv_pkg::*;
#(
  parameter int IMEM_SIZE = 65536,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic [3:0]        imem_wr_be,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_error
);

  localparam logic [ADDR_W:0] SIZE_CNT = (ADDR_W + 1)'(IMEM_SIZE);

  t_ldr_state      state;
  logic [ADDR_W:0] byte_idx;
  logic            accept;
  logic            restart;

  assign in_ready = (state == LDR_LOAD) && (byte_idx < SIZE_CNT);
  assign accept   = in_valid && in_ready;
  // start_load is only honoured outside an active load.
  assign restart  = start_load && (state != LDR_LOAD);

  rrv_byte_packer #(
    .ADDR_W(ADDR_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (restart),
    .accept   (accept),
    .byte_addr(byte_idx[ADDR_W-1:0]),
    .data     (in_data),
    .last     (in_last),
    .wr_en    (imem_wr_en),
    .wr_addr  (imem_wr_addr),
    .wr_data  (imem_wr_data),
    .wr_be    (imem_wr_be)
  );

  // Load sequencing; core release lags the final write by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LDR_IDLE;
      byte_idx   <= {(ADDR_W + 1){1'b0}};
      core_rst   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      case (state)
        LDR_IDLE: begin
          core_rst  <= 1'b1;
          load_done <= 1'b0;
          if (restart) begin
            state      <= LDR_LOAD;
            byte_idx   <= {(ADDR_W + 1){1'b0}};
            load_error <= 1'b0;
          end
        end
        LDR_LOAD: begin
          core_rst  <= 1'b1;
          load_done <= 1'b0;
          if (accept) begin
            byte_idx <= byte_idx + {{ADDR_W{1'b0}}, 1'b1};
            if (in_last) begin
              state <= LDR_DONE;
            end
          end else if (in_valid && (byte_idx == SIZE_CNT)) begin
            state      <= LDR_ERROR;
            load_error <= 1'b1;
          end
        end
        LDR_DONE: begin
          if (restart) begin
            state     <= LDR_LOAD;
            byte_idx  <= {(ADDR_W + 1){1'b0}};
            core_rst  <= 1'b1;
            load_done <= 1'b0;
          end else begin
            core_rst  <= 1'b0;
            load_done <= 1'b1;
          end
        end
        LDR_ERROR: begin
          core_rst <= 1'b1;
          if (restart) begin
            state      <= LDR_LOAD;
            byte_idx   <= {(ADDR_W + 1){1'b0}};
            load_error <= 1'b0;
          end
        end
        default: begin
          state    <= LDR_IDLE;
          core_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rrv_imem_loader.sv
// Randomized and directed bench for rrv_imem_loader with a behavioural model.
module tb_rrv_imem_loader;

  localparam int SIZE = 16;
  localparam int AW   = 4;
  localparam int MI = 0, ML = 1, MD = 2, ME = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_load;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_ready;
  logic          imem_wr_en;
  logic [AW-1:0] imem_wr_addr;
  logic [31:0]   imem_wr_data;
  logic [3:0]    imem_wr_be;
  logic          core_rst;
  logic          load_done;
  logic          load_error;

  rrv_imem_loader #(.IMEM_SIZE(SIZE), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start_load(start_load), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data), .imem_wr_be(imem_wr_be),
    .core_rst(core_rst), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode, byte count, partial word, expected outputs.
  int            m_mode;
  int            m_cnt;
  int            prev_mode;
  logic [7:0]    m_b [4];
  logic [3:0]    m_fill;
  logic          e_wr;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_data;
  logic [3:0]    e_be;
  logic          e_core_rst;
  logic          e_done;
  logic          e_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = MI; m_cnt = 0; m_fill = 4'b0000;
      for (int i = 0; i < 4; i++) m_b[i] = 8'h00;
      e_wr = 1'b0; e_addr = '0; e_data = 32'h0; e_be = 4'b0000;
      e_core_rst = 1'b1; e_done = 1'b0; e_err = 1'b0;
    end else begin
      prev_mode = m_mode;
      e_wr = 1'b0;
      if (m_mode != ML && start_load) begin
        m_mode = ML; m_cnt = 0; m_fill = 4'b0000; e_err = 1'b0;
        for (int i = 0; i < 4; i++) m_b[i] = 8'h00;
      end else if (m_mode == ML && in_valid) begin
        if (m_cnt < SIZE) begin
          m_b[m_cnt % 4] = in_data;
          m_fill[m_cnt % 4] = 1'b1;
          if ((m_cnt % 4 == 3) || in_last) begin
            e_wr   = 1'b1;
            e_addr = AW'(m_cnt - (m_cnt % 4));
            e_data = {m_b[3], m_b[2], m_b[1], m_b[0]};
            e_be   = m_fill;
            m_fill = 4'b0000;
            for (int i = 0; i < 4; i++) m_b[i] = 8'h00;
          end
          m_cnt++;
          if (in_last) m_mode = MD;
        end else begin
          m_mode = ME; e_err = 1'b1;
        end
      end
      e_done     = (prev_mode == MD) && (m_mode == MD);
      e_core_rst = !e_done;
    end
  end

  // Write log and release timing for the literal checks.
  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  logic [3:0]    log_be[$];
  int            cyc = 0;
  int            last_wr_cyc = 0;
  int            rel_cyc = 0;
  logic          prev_core_rst = 1'b1;

  always @(negedge clk) begin
    cyc++;
    chk("in_ready",   in_ready,   (m_mode == ML) && (m_cnt < SIZE));
    chk("wr_en",      imem_wr_en, e_wr);
    chk("core_rst",   core_rst,   e_core_rst);
    chk("load_done",  load_done,  e_done);
    chk("load_error", load_error, e_err);
    if (e_wr) begin
      chk("wr_addr", imem_wr_addr, e_addr);
      chk("wr_data", imem_wr_data, e_data);
      chk("wr_be",   imem_wr_be,   e_be);
    end
    if (imem_wr_en) begin
      log_addr.push_back(imem_wr_addr);
      log_data.push_back(imem_wr_data);
      log_be.push_back(imem_wr_be);
      last_wr_cyc = cyc;
    end
    if (prev_core_rst && !core_rst) rel_cyc = cyc;
    prev_core_rst = core_rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic log_clear();
    log_addr.delete(); log_data.delete(); log_be.delete();
  endtask

  task automatic do_start();
    start_load = 1'b1; tick(); start_load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
    bit done;
    for (int g = 0; g < gap; g++) begin in_valid = 1'b0; tick(); end
    in_valid = 1'b1; in_data = d; in_last = l;
    done = 1'b0;
    for (int a = 0; a < 3 && !done; a++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    int len;
    bit has_last;
    rst = 1'b1; start_load = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (3) tick();
    chk("rst_core_rst", core_rst, 1'b1);
    chk("rst_ready", in_ready, 1'b0);
    rst = 1'b0; tick();

    // 1: eight bytes 01..08
    log_clear(); do_start();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8, 0);
    repeat (2) tick();
    chk("t1_nwr", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("t1_a0", log_addr[0], 0);  chk("t1_d0", log_data[0], 32'h04030201);
      chk("t1_b0", log_be[0], 4'hF); chk("t1_a1", log_addr[1], 4);
      chk("t1_d1", log_data[1], 32'h08070605); chk("t1_b1", log_be[1], 4'hF);
    end
    chk("t1_release_lag", rel_cyc - last_wr_cyc, 1);
    chk("t1_done", load_done, 1'b1);

    // 2 / 6: restart from DONE with a partial final word
    log_clear(); do_start();
    chk("t2_core_rst_in_load", core_rst, 1'b1);
    send_byte(8'hAA, 0, 0); send_byte(8'hBB, 0, 0); send_byte(8'hCC, 0, 0);
    send_byte(8'hDD, 0, 0); send_byte(8'hEE, 0, 0); send_byte(8'hFF, 1, 0);
    repeat (2) tick();
    chk("t2_nwr", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("t2_d0", log_data[0], 32'hDDCCBBAA);
      chk("t2_a1", log_addr[1], 4); chk("t2_d1", log_data[1], 32'h0000FFEE);
      chk("t2_b1", log_be[1], 4'h3);
    end

    // 3: overflow
    log_clear(); do_start();
    for (int i = 0; i < 16; i++) send_byte(8'(i + 8'h40), 0, 0);
    tick();
    chk("t3_no_err_yet", load_error, 1'b0);
    send_byte(8'h99, 0, 0);
    chk("t3_nwr", log_addr.size(), 4);
    if (log_addr.size() == 4) chk("t3_a3", log_addr[3], 4'hC);
    chk("t3_err", load_error, 1'b1);
    chk("t3_core_rst", core_rst, 1'b1);
    chk("t3_ready", in_ready, 1'b0);
    do_start(); tick();
    chk("t3_err_clr", load_error, 1'b0);
    send_byte(8'h01, 1, 0); tick();

    // 4: gapped valid, and start_load with in_valid in DONE
    log_clear();
    in_valid = 1'b1; in_data = 8'h77; start_load = 1'b1; tick();
    start_load = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'(8'h10 * i + 8'h3), i == 3, 1);
    repeat (3) tick();
    chk("t4_nwr", log_addr.size(), 1);
    if (log_addr.size() == 1) chk("t4_d", log_data[0], 32'h33231303);

    // 5: reset mid-load, then a fresh two-byte image
    log_clear(); do_start();
    for (int i = 0; i < 3; i++) send_byte(8'hC0, 0, 0);
    do_reset();
    chk("t5_nwr", log_addr.size(), 0);
    chk("t5_core_rst", core_rst, 1'b1);
    do_start(); send_byte(8'h5A, 0, 0); send_byte(8'h6B, 1, 0); tick();
    chk("t5_nwr2", log_addr.size(), 1);
    if (log_addr.size() == 1) begin
      chk("t5_a", log_addr[0], 0); chk("t5_d", log_data[0], 32'h00006B5A);
      chk("t5_b", log_be[0], 4'h3);
    end

    // boundary: full-size image ending on the last byte
    log_clear(); do_start();
    for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15, 0);
    repeat (2) tick();
    chk("bnd_nwr", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      chk("bnd_a", log_addr[3], 4'hC); chk("bnd_b", log_be[3], 4'hF);
    end
    chk("bnd_done", load_done, 1'b1);

    // random images against the model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      do_start();
      len = $urandom_range(1, 20);
      has_last = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 14) == 0) do_start();
        send_byte(8'($urandom), has_last && (i == len - 1), $urandom_range(0, 2));
      end
      repeat (2) tick();
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b1; in_data = 8'($urandom); start_load = 1'b1; tick();
        in_valid = 1'b0; start_load = 1'b0;
        send_byte(8'($urandom), 1, 0); tick();
      end
      if (!has_last) do_reset();
    end
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
